floo_wormhole_arbiter: RTL and testbench

//  Round-robin wormhole arbiter sharing one router output port between NumInputs input ports.

---
 rtl/floo_pkg.sv | 18 +
 rtl/floo_rr_pick.sv | 44 ++++
 rtl/floo_wormhole_arbiter.sv | 114 +++++++++++
 tb/tb_floo_wormhole_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// Shared types for the floo wormhole arbiter: arbiter state encoding and the
// default flit layout (header with a last-flit marker plus payload).
package floo_pkg;

  localparam int unsigned FlitDataWidth = 8;

  typedef enum logic [1:0] {ArbIdle, ArbHold, ArbLocked} wh_arb_state_e;

  typedef struct packed {
    logic last;
  } hdr_t;

  typedef struct packed {
    hdr_t                     hdr;
    logic [FlitDataWidth-1:0] payload;
  } flit_t;

endpackage

// File: rtl/floo_rr_pick.sv
// Combinational round-robin picker: first set valid bit at or after ptr_i,
// built as rotate-down, lowest-set-bit search, rotate-back (any NumInputs).
module floo_rr_pick #(
  parameter int unsigned NumInputs = 5,
  parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic [NumInputs-1:0] valid_i,
  input  logic [IdxWidth-1:0]  ptr_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 any_o
);

  logic [NumInputs-1:0] rotated;
  logic [IdxWidth-1:0]  first;
  logic [IdxWidth:0]    back_sum;

  always_comb begin
    logic [IdxWidth:0] src;
    rotated = '0;
    src     = '0;
    for (int i = 0; i < NumInputs; i++) begin
      src = {1'b0, ptr_i} + (IdxWidth+1)'(i);
      if (src >= (IdxWidth+1)'(NumInputs)) src = src - (IdxWidth+1)'(NumInputs);
      rotated[i] = valid_i[src[IdxWidth-1:0]];
    end
  end

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    first = '0;
    for (int i = NumInputs - 1; i >= 0; i--) begin
      if (rotated[i]) first = IdxWidth'(i);
    end
  end

  always_comb begin
    back_sum = {1'b0, first} + {1'b0, ptr_i};
    if (back_sum >= (IdxWidth+1)'(NumInputs)) back_sum = back_sum - (IdxWidth+1)'(NumInputs);
  end

  assign any_o = |valid_i;
  assign idx_o = any_o ? back_sum[IdxWidth-1:0] : '0;

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// Round-robin wormhole arbiter for one router output port: grants one input,
// holds it through output stalls and locks it until the last flit is accepted.
module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs = 5,
  parameter type         flit_t    = floo_pkg::flit_t,
  parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumInputs-1:0]  valid_i,
  output logic [NumInputs-1:0]  ready_o,
  input  flit_t [NumInputs-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output flit_t                 data_o,
  output logic [IdxWidth-1:0]   gnt_idx_o,
  output logic                  locked_o
);

  wh_arb_state_e       state_q;
  logic [IdxWidth-1:0] rr_ptr_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_any;
  logic [IdxWidth-1:0] sel;
  logic                hs;
  logic                last;

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
    return (idx == IdxWidth'(NumInputs - 1)) ? '0 : idx + 1'b1;
  endfunction

  floo_rr_pick #(
    .NumInputs (NumInputs),
    .IdxWidth  (IdxWidth)
  ) i_rr_pick (
    .valid_i (valid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Once a packet owns the port, later-arriving inputs cannot steal it.
  assign sel = (state_q == ArbIdle) ? pick_idx : lock_idx_q;

  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    ready_o = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (sel == IdxWidth'(i)) begin
        valid_o    = valid_i[i];
        data_o     = data_i[i];
        ready_o[i] = ready_i;
      end
    end
  end

  assign hs        = valid_o & ready_i;
  assign last      = data_o.hdr.last;
  assign gnt_idx_o = sel;
  assign locked_o  = (state_q == ArbLocked);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (valid_o && !ready_i) begin
            state_q    <= ArbHold;
            lock_idx_q <= sel;
          end else if (hs && !last) begin
            state_q    <= ArbLocked;
            lock_idx_q <= sel;
          end else if (hs && last) begin
            rr_ptr_q <= wrap_inc(sel);
          end
        end
        ArbHold: begin
          if (hs && !last) begin
            state_q <= ArbLocked;
          end else if (hs && last) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= wrap_inc(lock_idx_q);
          end
        end
        ArbLocked: begin
          if (hs && last) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= wrap_inc(lock_idx_q);
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ready_o));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != ArbIdle && valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

  logic unused_any;
  assign unused_any = pick_any;

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Directed bench for floo_wormhole_arbiter with NumInputs=5 and hand-computed
// grant sequences covering round-robin, locking, stall hold, wrap and reset.
module tb_floo_wormhole_arbiter;
  import floo_pkg::*;

  localparam int unsigned N = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid;
  logic [N-1:0]  ready_o;
  flit_t [N-1:0] data;
  logic          valid_o;
  logic          ready_i;
  flit_t         data_o;
  logic [2:0]    gnt_idx;
  logic          locked;

  int n_chk = 0;
  int n_err = 0;

  floo_wormhole_arbiter #(.NumInputs(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid),
    .ready_o   (ready_o),
    .data_i    (data),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .gnt_idx_o (gnt_idx),
    .locked_o  (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mkflit(input logic last, input logic [7:0] payload);
    flit_t f;
    f.hdr.last = last;
    f.payload  = payload;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_gnt[5] = '{1, 2, 4, 1, 2};

  initial begin
    rst_n   = 1'b0;
    valid   = '0;
    ready_i = 1'b0;
    for (int i = 0; i < N; i++) data[i] = mkflit(1'b1, 8'(8'h10 + i));

    // 1: reset state
    #2;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_gnt", 32'(gnt_idx), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 2: round-robin over 1-flit packets
    valid   = 5'b10110;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 32'(gnt_idx), 32'(exp_gnt[k]));
      chk($sformatf("rr_ready%0d", k), 32'(ready_o), 32'(5'b1 << exp_gnt[k]));
      tick();
    end
    valid = '0;
    tick();

    // 3: input 2 sends 3 flits, input 0 waits (rr_ptr is 3 here)
    valid   = 5'b00100;
    data[2] = mkflit(1'b0, 8'hA1);
    #1;
    chk("wh_gnt_head", 32'(gnt_idx), 32'd2);
    chk("wh_locked_head", 32'(locked), 32'd0);
    tick();
    valid   = 5'b00101;
    data[0] = mkflit(1'b1, 8'hB0);
    data[2] = mkflit(1'b0, 8'hA2);
    #1;
    chk("wh_gnt_body", 32'(gnt_idx), 32'd2);
    chk("wh_ready_body", 32'(ready_o), 32'b00100);
    chk("wh_locked_body", 32'(locked), 32'd1);
    tick();
    data[2] = mkflit(1'b1, 8'hA3);
    #1;
    chk("wh_ready_tail", 32'(ready_o), 32'b00100);
    chk("wh_locked_tail", 32'(locked), 32'd1);
    chk("wh_data_tail", 32'(data_o.payload), 32'hA3);
    tick();
    valid = 5'b00001;
    #1;
    chk("wh_gnt_next", 32'(gnt_idx), 32'd0);
    chk("wh_ready_next", 32'(ready_o), 32'b00001);
    chk("wh_locked_next", 32'(locked), 32'd0);
    chk("wh_data_next", 32'(data_o.payload), 32'hB0);
    tick();
    valid = '0;
    tick();

    // 4: stall hold (rr_ptr is 1 here)
    valid   = 5'b01000;
    ready_i = 1'b0;
    data[1] = mkflit(1'b1, 8'hC1);
    data[3] = mkflit(1'b1, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) valid = 5'b01010;
      #1;
      chk($sformatf("hold_gnt%0d", k), 32'(gnt_idx), 32'd3);
      chk($sformatf("hold_ready%0d", k), 32'(ready_o), 32'd0);
      chk($sformatf("hold_data%0d", k), 32'(data_o.payload), 32'hC3);
      if (k > 0) chk($sformatf("hold_state%0d", k), 32'(dut.state_q), 32'(ArbHold));
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("hold_accept_gnt", 32'(gnt_idx), 32'd3);
    chk("hold_accept_ready", 32'(ready_o), 32'b01000);
    tick();
    valid = 5'b00010;
    #1;
    chk("hold_after_gnt", 32'(gnt_idx), 32'd1);
    tick();
    valid = '0;
    tick();

    // 5: pointer wrap (rr_ptr is 2 here; one packet from 3 moves it to 4)
    valid = 5'b01000;
    tick();
    chk("wrap_ptr4", 32'(dut.rr_ptr_q), 32'd4);
    valid = 5'b10001;
    #1;
    chk("wrap_gnt4", 32'(gnt_idx), 32'd4);
    tick();
    chk("wrap_ptr0", 32'(dut.rr_ptr_q), 32'd0);
    #1;
    chk("wrap_gnt0", 32'(gnt_idx), 32'd0);
    tick();
    chk("wrap_ptr1", 32'(dut.rr_ptr_q), 32'd1);
    valid = '0;
    tick();

    // 6: async reset while locked
    valid   = 5'b00010;
    data[1] = mkflit(1'b0, 8'hD1);
    #1;
    chk("rst6_gnt", 32'(gnt_idx), 32'd1);
    tick();
    valid   = '0;
    ready_i = 1'b0;
    tick();
    chk("rst6_bubble_locked", 32'(locked), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst6_state", 32'(dut.state_q), 32'(ArbIdle));
    chk("rst6_ptr", 32'(dut.rr_ptr_q), 32'd0);
    chk("rst6_locked", 32'(locked), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    valid   = 5'b00011;
    ready_i = 1'b1;
    data[0] = mkflit(1'b1, 8'hE0);
    data[1] = mkflit(1'b1, 8'hE1);
    #1;
    chk("rst6_restart_gnt", 32'(gnt_idx), 32'd0);
    chk("rst6_restart_ready", 32'(ready_o), 32'b00001);
    tick();
    chk("rst6_restart_ptr", 32'(dut.rr_ptr_q), 32'd1);
    valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
